// File: rtl/gen_pulse_stretcher.sv
// gen_pulse_stretcher
// Turns single-cycle event pulses into spaced high/low windows on a level
// line. Each accepted event produces one high window of HIGH_CYCLES followed
// by at least LOW_CYCLES low. A far-side synchronizer and edge detector
// therefore see exactly one rising edge per event. Events that arrive while a
// window is running are queued in a saturating pending counter. Events that
// cannot be queued are dropped, and the drop sets a sticky overflow flag.
//
// state   | meaning
// --------+----------------------------------------------------------
// ST_IDLE | line low, nothing in flight; launches on any request
// ST_HIGH | line high, timer counts down the high window
// ST_LOW  | line low, timer counts down the minimum low gap
module gen_pulse_stretcher #(
    parameter int HIGH_CYCLES = 4,
    parameter int LOW_CYCLES  = 4,
    parameter int PEND_BITS   = 3
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 pulse_in,
    input  logic                 clear,
    output logic                 sig_out,
    output logic                 busy,
    output logic [PEND_BITS-1:0] pending,
    output logic                 overflow
);

    localparam int MAX_CYC = (HIGH_CYCLES > LOW_CYCLES) ? HIGH_CYCLES : LOW_CYCLES;
    // Keep at least one timer bit so that 1-cycle windows still elaborate.
    localparam int TW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [TW-1:0]        HIGH_LOAD = TW'(HIGH_CYCLES - 1);
    localparam logic [TW-1:0]        LOW_LOAD  = TW'(LOW_CYCLES - 1);
    localparam logic [TW-1:0]        TIMER_ONE = TW'(1);
    localparam logic [PEND_BITS-1:0] PEND_ONE  = PEND_BITS'(1);
    localparam logic [PEND_BITS-1:0] PEND_MAX  = '1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } state_t;

    state_t               r_state;
    logic [TW-1:0]        r_timer;
    logic                 r_sig;
    logic [PEND_BITS-1:0] r_pending;
    logic                 r_overflow;

    logic w_pend_nz;
    logic w_req;
    logic w_tc;
    logic w_launch;
    logic w_consume;
    logic w_direct;
    logic w_accept;

    assign w_pend_nz = (r_pending != '0);
    assign w_req     = pulse_in | w_pend_nz;
    assign w_tc      = (r_timer == '0);
    assign w_launch  = w_req & ((r_state == ST_IDLE) | ((r_state == ST_LOW) & w_tc));
    // A launch drains the queue first. Only with an empty queue does the
    // launch take the incoming pulse directly, bypassing the counter.
    assign w_consume = w_launch & w_pend_nz;
    assign w_direct  = w_launch & ~w_pend_nz;
    assign w_accept  = pulse_in & ~w_direct;

    // Window sequencing, timer and pending/overflow bookkeeping.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state    <= ST_IDLE;
            r_timer    <= '0;
            r_sig      <= 1'b0;
            r_pending  <= '0;
            r_overflow <= 1'b0;
        end else if (clear) begin
            r_state    <= ST_IDLE;
            r_timer    <= '0;
            r_sig      <= 1'b0;
            r_pending  <= '0;
            r_overflow <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_launch) begin
                        r_state <= ST_HIGH;
                        r_sig   <= 1'b1;
                        r_timer <= HIGH_LOAD;
                    end
                end
                ST_HIGH: begin
                    if (w_tc) begin
                        r_state <= ST_LOW;
                        r_sig   <= 1'b0;
                        r_timer <= LOW_LOAD;
                    end else begin
                        r_timer <= r_timer - TIMER_ONE;
                    end
                end
                ST_LOW: begin
                    if (w_tc) begin
                        if (w_launch) begin
                            r_state <= ST_HIGH;
                            r_sig   <= 1'b1;
                            r_timer <= HIGH_LOAD;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end else begin
                        r_timer <= r_timer - TIMER_ONE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_sig   <= 1'b0;
                    r_timer <= '0;
                end
            endcase

            // Accept and consume in the same cycle cancel out, even when the
            // queue is full, so that case is never counted as a drop.
            if (w_accept && !w_consume) begin
                if (r_pending == PEND_MAX) begin
                    r_overflow <= 1'b1;
                end else begin
                    r_pending <= r_pending + PEND_ONE;
                end
            end else if (!w_accept && w_consume) begin
                r_pending <= r_pending - PEND_ONE;
            end
        end
    end

    assign sig_out  = r_sig;
    assign pending  = r_pending;
    assign overflow = r_overflow;
    assign busy     = (r_state != ST_IDLE) | w_pend_nz;

endmodule

// File: tb/tb_gen_pulse_stretcher.sv
// Scoreboard bench for gen_pulse_stretcher (HIGH=4, LOW=4, PEND_BITS=3).
// Cycle n is the clock period that ends at edge n, counted from the start of
// each scenario. An input driven during cycle n is sampled at edge n, and a
// registered response first shows up in cycle n+1. Each scenario pushes its
// hand-computed expectations before it drives anything. Two monitor
// processes then check the DUT:
//   - a sample checker that compares output values on their due cycle;
//   - a window checker that pops an expected (start, length) entry each
//     time a high window on sig_out ends.
module tb_gen_pulse_stretcher;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       pulse_in;
    logic       clear;
    logic       sig_out;
    logic       busy;
    logic [2:0] pending;
    logic       overflow;

    gen_pulse_stretcher #(
        .HIGH_CYCLES(4),
        .LOW_CYCLES (4),
        .PEND_BITS  (3)
    ) dut (
        .clk     (clk),
        .n_rst   (n_rst),
        .pulse_in(pulse_in),
        .clear   (clear),
        .sig_out (sig_out),
        .busy    (busy),
        .pending (pending),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        int    cyc;
        string name;
        int    sel;   // 0 sig_out, 1 busy, 2 pending, 3 overflow
        int    val;
    } chk_t;

    typedef struct {
        int start;
        int len;
    } win_t;

    chk_t chq[$];
    win_t wq[$];

    int total = 0;
    int bad   = 0;
    int pcount = 0;
    int base   = 0;

    always @(posedge clk) pcount <= pcount + 1;

    task automatic compare(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int sample(input int sel);
        case (sel)
            0:       return int'(sig_out);
            1:       return int'(busy);
            2:       return int'(pending);
            default: return int'(overflow);
        endcase
    endfunction

    // Monitor: sample away from the active edge, score due checkpoints and
    // finished windows.
    int   w_start   = 0;
    logic prev_sig  = 1'b0;
    always @(negedge clk) begin
        int cur;
        #1;
        cur = pcount - base;
        for (int i = chq.size() - 1; i >= 0; i--) begin
            if (chq[i].cyc == cur) begin
                compare(chq[i].name, sample(chq[i].sel), chq[i].val);
                chq.delete(i);
            end
        end
        if (sig_out && !prev_sig) w_start = cur;
        if (!sig_out && prev_sig) begin
            if (wq.size() == 0) begin
                compare("unexpected_window_start", w_start, -1);
            end else begin
                win_t w;
                w = wq.pop_front();
                compare("window_start", w_start, w.start);
                compare("window_len", cur - w_start, w.len);
            end
        end
        prev_sig = sig_out;
    end

    task automatic expect_at(input int cyc, input string name, input int sel, input int val);
        chk_t c;
        c.cyc = cyc; c.name = name; c.sel = sel; c.val = val;
        chq.push_back(c);
    endtask

    task automatic expect_win(input int start, input int len);
        win_t w;
        w.start = start; w.len = len;
        wq.push_back(w);
    endtask

    function automatic bit in_q(input int q[$], input int v);
        foreach (q[i]) if (q[i] == v) return 1'b1;
        return 1'b0;
    endfunction

    // Called at the negedge of scenario cycle 0 and drives cycles 0..ncyc-1.
    task automatic run_scn(input int ncyc, input int pulses[$], input int clears[$],
                           input int rst_on, input int rst_off);
        for (int c = 0; c < ncyc; c++) begin
            if (c > 0) @(negedge clk);
            pulse_in = in_q(pulses, c);
            clear    = in_q(clears, c);
            if (c == rst_on)  n_rst = 1'b0;
            if (c == rst_off) n_rst = 1'b1;
        end
        @(negedge clk);
        pulse_in = 1'b0;
        clear    = 1'b0;
        #2;
        compare("leftover_checkpoints", chq.size(), 0);
        compare("missing_windows", wq.size(), 0);
        chq.delete();
        wq.delete();
    endtask

    task automatic start_scn();
        @(negedge clk);
        base = pcount;
    endtask

    int none[$];
    int p[$];
    int cl[$];

    initial begin
        n_rst    = 1'b0;
        pulse_in = 1'b0;
        clear    = 1'b0;
        repeat (3) @(negedge clk);
        n_rst = 1'b1;

        // Single event: reset state at cycle 0, then one pulse at cycle 10.
        start_scn();
        expect_at(0,  "rst_sig",   0, 0);
        expect_at(0,  "rst_busy",  1, 0);
        expect_at(0,  "rst_pend",  2, 0);
        expect_at(0,  "rst_ovf",   3, 0);
        expect_at(10, "s1_sig10",  0, 0);
        expect_at(11, "s1_sig11",  0, 1);
        expect_at(14, "s1_sig14",  0, 1);
        expect_at(15, "s1_sig15",  0, 0);
        expect_at(11, "s1_busy11", 1, 1);
        expect_at(18, "s1_busy18", 1, 1);
        expect_at(19, "s1_busy19", 1, 0);
        expect_at(12, "s1_pend12", 2, 0);
        expect_win(11, 4);
        p = {10};
        run_scn(25, p, none, -1, -1);

        // Three consecutive pulses: two queue, back-to-back period of 8.
        start_scn();
        expect_at(12, "s2_pend12", 2, 1);
        expect_at(13, "s2_pend13", 2, 2);
        expect_at(18, "s2_pend18", 2, 2);
        expect_at(19, "s2_pend19", 2, 1);
        expect_at(26, "s2_pend26", 2, 1);
        expect_at(27, "s2_pend27", 2, 0);
        expect_at(34, "s2_busy34", 1, 1);
        expect_at(35, "s2_busy35", 1, 0);
        expect_win(11, 4);
        expect_win(19, 4);
        expect_win(27, 4);
        p = {10, 11, 12};
        run_scn(40, p, none, -1, -1);

        // Ten pulses, cycles 10..19. At cycle 18, pending=7 meets the LOW
        // terminal count, so the accept and the consume cancel with no drop.
        // The pulse at cycle 19 finds the queue full and is dropped.
        start_scn();
        expect_at(18, "s3_pend18", 2, 7);
        expect_at(19, "s3_pend19", 2, 7);
        expect_at(19, "s3_ovf19",  3, 0);
        expect_at(20, "s3_pend20", 2, 7);
        expect_at(20, "s3_ovf20",  3, 1);
        expect_at(27, "s3_pend27", 2, 6);
        expect_at(75, "s3_pend75", 2, 0);
        expect_at(82, "s3_busy82", 1, 1);
        expect_at(83, "s3_busy83", 1, 0);
        expect_at(90, "s3_ovf90",  3, 1);
        for (int k = 0; k < 9; k++) expect_win(11 + 8 * k, 4);
        p = {10, 11, 12, 13, 14, 15, 16, 17, 18, 19};
        run_scn(95, p, none, -1, -1);

        // Clear in the second cycle of a window with pending=3, together with
        // a pulse. Overflow is still set from the previous scenario.
        start_scn();
        expect_at(0,  "s4_ovf0",   3, 1);
        expect_at(19, "s4_pend19", 2, 3);
        expect_at(20, "s4_pend20", 2, 3);
        expect_at(20, "s4_sig20",  0, 1);
        expect_at(21, "s4_sig21",  0, 0);
        expect_at(21, "s4_pend21", 2, 0);
        expect_at(21, "s4_ovf21",  3, 0);
        expect_at(21, "s4_busy21", 1, 0);
        expect_at(35, "s4_busy35", 1, 0);
        expect_win(11, 4);
        expect_win(19, 2);
        p  = {10, 11, 12, 13, 14, 20};
        cl = {20};
        run_scn(40, p, cl, -1, -1);

        // Asynchronous reset during LOW with pending=2, then a single event.
        start_scn();
        expect_at(15, "s5_pend15", 2, 2);
        expect_at(15, "s5_busy15", 1, 1);
        expect_at(16, "s5_sig16",  0, 0);
        expect_at(16, "s5_busy16", 1, 0);
        expect_at(16, "s5_pend16", 2, 0);
        expect_at(16, "s5_ovf16",  3, 0);
        expect_at(25, "s5_sig25",  0, 0);
        expect_at(26, "s5_sig26",  0, 1);
        expect_at(29, "s5_sig29",  0, 1);
        expect_at(30, "s5_sig30",  0, 0);
        expect_at(33, "s5_busy33", 1, 1);
        expect_at(34, "s5_busy34", 1, 0);
        expect_win(11, 4);
        expect_win(26, 4);
        p = {10, 11, 12, 25};
        run_scn(40, p, none, 16, 18);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
